// File: rtl/button_pkg.sv
// button_pkg: shared types and constants for the player-control front-end.
//   rpt_state_t    : auto-repeat FSM states for the move buttons
//   BTN_*          : bit positions within btn_raw / btn_level
//   DEF_*          : default timing at 25 MHz
//   cnt_width()    : counter width for a cycle-count parameter
package button_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  localparam int unsigned NUM_BTNS  = 3;
  localparam int unsigned BTN_DROP  = 0;
  localparam int unsigned BTN_RIGHT = 1;
  localparam int unsigned BTN_LEFT  = 2;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 250_000;     // 10 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 12_500_000;  // 500 ms
  localparam int unsigned DEF_REPEAT_PERIOD   = 3_750_000;   // 150 ms

  // Timing parameters are expected to be >= 2; the guard keeps the width
  // legal if someone passes 1 anyway.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce: one push-button channel.
//   2-flop synchronizer -> debounce filter -> press-edge detector.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   raw      : raw pin, active-high
//   level    : debounced level (registered)
//   press    : high for the single cycle after level rises
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic          level_q, level_d;
  logic          level_dly_q, level_dly_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      dcnt_q      <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      dcnt_q      <= dcnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
    end
  end

  always_comb begin
    sync1_d     = raw;
    sync2_d     = sync1_q;
    level_dly_d = level_q;
    level_d     = level_q;
    dcnt_d      = '0;
    // The counter only survives an unbroken run of disagreement; a single
    // agreeing cycle restarts the qualification window.
    if (sync2_q != level_q) begin
      if (dcnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        dcnt_d = dcnt_q + CW'(1);
      end
    end
  end

  assign level = level_q;
  assign press = level_q & ~level_dly_q;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: turns the three raw player buttons into clean
// single-cycle commands for the connect-four core.
// Ports:
//   clk_25MHz  : clock, rising edge
//   rst        : asynchronous active-high reset
//   btn_raw    : raw pins [0]=drop [1]=right [2]=left
//   busy       : core cannot accept a command this cycle
//   drop_piece : one-cycle command pulse
//   move_right : one-cycle command pulse (auto-repeats while held)
//   move_left  : one-cycle command pulse (auto-repeats while held)
//   btn_level  : debounced levels, same order as btn_raw
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       clk_25MHz,
  input  logic       rst,
  input  logic [2:0] btn_raw,
  input  logic       busy,
  output logic       drop_piece,
  output logic       move_right,
  output logic       move_left,
  output logic [2:0] btn_level
);

  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = cnt_width(RMAX);

  logic [2:0] level;
  logic [2:0] press;
  logic [2:0] evt;
  logic       conflict;

  rpt_state_t        rpt_state_q [BTN_RIGHT:BTN_LEFT];
  rpt_state_t        rpt_state_d [BTN_RIGHT:BTN_LEFT];
  logic [RW-1:0]     rcnt_q      [BTN_RIGHT:BTN_LEFT];
  logic [RW-1:0]     rcnt_d      [BTN_RIGHT:BTN_LEFT];

  logic [2:0] pending_q, pending_d;
  logic [2:0] pulse_q, pulse_d;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_drop (
    .clk   (clk_25MHz),
    .rst   (rst),
    .raw   (btn_raw[BTN_DROP]),
    .level (level[BTN_DROP]),
    .press (press[BTN_DROP])
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk   (clk_25MHz),
    .rst   (rst),
    .raw   (btn_raw[BTN_RIGHT]),
    .level (level[BTN_RIGHT]),
    .press (press[BTN_RIGHT])
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk   (clk_25MHz),
    .rst   (rst),
    .raw   (btn_raw[BTN_LEFT]),
    .level (level[BTN_LEFT]),
    .press (press[BTN_LEFT])
  );

  // Repeat FSM state registers
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      for (int unsigned i = BTN_RIGHT; i <= BTN_LEFT; i++) begin
        rpt_state_q[i] <= IDLE;
        rcnt_q[i]      <= '0;
      end
    end else begin
      for (int unsigned i = BTN_RIGHT; i <= BTN_LEFT; i++) begin
        rpt_state_q[i] <= rpt_state_d[i];
        rcnt_q[i]      <= rcnt_d[i];
      end
    end
  end

  // Repeat FSM next-state and command events
  always_comb begin
    conflict      = level[BTN_RIGHT] & level[BTN_LEFT];
    evt           = '0;
    evt[BTN_DROP] = press[BTN_DROP];
    for (int unsigned i = BTN_RIGHT; i <= BTN_LEFT; i++) begin
      rpt_state_d[i] = rpt_state_q[i];
      rcnt_d[i]      = rcnt_q[i];
      if (!level[i]) begin
        rpt_state_d[i] = IDLE;
        rcnt_d[i]      = '0;
      end else if (conflict) begin
        // Parking both held buttons in HELD with a cleared counter means the
        // survivor of a conflict waits a full REPEAT_DELAY before moving.
        rpt_state_d[i] = HELD;
        rcnt_d[i]      = '0;
      end else begin
        unique case (rpt_state_q[i])
          IDLE: begin
            if (press[i]) begin
              evt[i]         = 1'b1;
              rpt_state_d[i] = HELD;
              rcnt_d[i]      = '0;
            end
          end
          HELD: begin
            if (rcnt_q[i] == RW'(REPEAT_DELAY - 1)) begin
              evt[i]         = 1'b1;
              rpt_state_d[i] = REPEAT;
              rcnt_d[i]      = '0;
            end else begin
              rcnt_d[i] = rcnt_q[i] + RW'(1);
            end
          end
          REPEAT: begin
            if (rcnt_q[i] == RW'(REPEAT_PERIOD - 1)) begin
              evt[i]    = 1'b1;
              rcnt_d[i] = '0;
            end else begin
              rcnt_d[i] = rcnt_q[i] + RW'(1);
            end
          end
          default: begin
            rpt_state_d[i] = IDLE;
            rcnt_d[i]      = '0;
          end
        endcase
      end
    end
  end

  // One-deep hold of events that arrive while the core is busy
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      pulse_q   <= '0;
    end else begin
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
    end
  end

  always_comb begin
    pending_d = pending_q;
    pulse_d   = '0;
    if (busy) begin
      pending_d = pending_q | evt;
    end else begin
      pulse_d = pending_q | evt;
      // Opposite moves buffered together carry no clear intent: drop both.
      if (pending_q[BTN_RIGHT] && pending_q[BTN_LEFT]) begin
        pulse_d[BTN_RIGHT] = 1'b0;
        pulse_d[BTN_LEFT]  = 1'b0;
      end
      pending_d = '0;
    end
  end

  assign drop_piece = pulse_q[BTN_DROP];
  assign move_right = pulse_q[BTN_RIGHT];
  assign move_left  = pulse_q[BTN_LEFT];
  assign btn_level  = level;

endmodule
